// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants and types for the VGA timing generator
package vga_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    AX_ACT  = 2'd0,
    AX_FP   = 2'd1,
    AX_SYNC = 2'd2,
    AX_BP   = 2'd3
  } axis_state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Largest axis total a 10-bit coordinate can represent.
  localparam int unsigned COORD_LIMIT = 1024;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter plus ACT/FP/SYNC/BP phase FSM
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BACK   = DEF_H_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [9:0] count,
  output logic [1:0] state,
  output logic       wrap
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  if (TOTAL > COORD_LIMIT) begin : g_total_check
    $error("vga_axis_counter: axis total exceeds the 10-bit coordinate range");
  end

  localparam coord_t LAST_ACT  = coord_t'(ACTIVE - 1);
  localparam coord_t LAST_FP   = coord_t'(ACTIVE + FRONT - 1);
  localparam coord_t LAST_SYNC = coord_t'(ACTIVE + FRONT + SYNC - 1);
  localparam coord_t LAST      = coord_t'(TOTAL - 1);

  coord_t      count_q, count_d;
  axis_state_t state_q, state_d;
  logic        at_last;

  assign at_last = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (adv) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        AX_ACT:  if (count_q == LAST_ACT)  state_d = AX_FP;
        AX_FP:   if (count_q == LAST_FP)   state_d = AX_SYNC;
        AX_SYNC: if (count_q == LAST_SYNC) state_d = AX_BP;
        AX_BP:   if (at_last)              state_d = AX_ACT;
        default:                           state_d = AX_BP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
      state_q <= AX_BP;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // state is the phase the counter enters on this edge, so the parent can
  // register its decode in step with count.
  assign count = count_q;
  assign state = state_d;
  assign wrap  = adv && at_last;

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster position, sync and frame/line marker generator
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x_val,
  output logic [9:0] y_val,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       line_start,
  output logic       frame_start
);

  logic [1:0] h_state_nxt, v_state_nxt;
  logic       h_wrap, v_wrap, v_adv;

  assign v_adv = pix_en && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pix_en),
    .count (x_val),
    .state (h_state_nxt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (v_adv),
    .count (y_val),
    .state (v_state_nxt),
    .wrap  (v_wrap)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Decode from the phases being entered so outputs match the new position.
  always_comb begin
    hsync_d       = (h_state_nxt == AX_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = (v_state_nxt == AX_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    de_d          = (h_state_nxt == AX_ACT) && (v_state_nxt == AX_ACT);
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_en  = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
